mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one multi-cycle, single-port unified memory between the fetch stage (read-only requester "if") and the memory stage (read/write requester "dm").
- Grants one transaction at a time and sequences the memory enable, address and write strobes.
- Waits a fixed memory latency, then returns read data and a one-cycle done pulse to the owning requester.
- Drives per-port stall signals that hold the processor pipeline while that port's access is outstanding.

Parameters:
MEM_LAT, 4, cycles from the mem_en cycle to the cycle in which mem_rdata is valid (legal range 1..15)
AW, 16, address width
DW, 16, data width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-low (asserted when 0)
if_req  in  1  fetch read request; held high until if_done
if_addr  in  AW  fetch address; stable while if_req high
if_rdata  out  DW  fetch read data; valid from if_done onward
if_done  out  1  one-cycle completion pulse to fetch
if_stall  out  1  if_req & ~if_done
dm_req  in  1  data request; held high until dm_done
dm_wr  in  1  1 = write, 0 = read; stable while dm_req high
dm_addr  in  AW  data address
dm_wdata  in  DW  write data
dm_rdata  out  DW  data read data; valid from dm_done onward
dm_done  out  1  one-cycle completion pulse to data port
dm_stall  out  1  dm_req & ~dm_done
mem_en  out  1  memory access strobe, exactly one cycle per transaction
mem_wr  out  1  write qualifier, valid only with mem_en
mem_addr  out  AW  latched transaction address
mem_wdata  out  DW  latched write data
mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  high in every state except IDLE
err  out  1  one-cycle pulse: the granted address has bit 0 set (misaligned)

Behaviour:
- Reset: while rst==0 at a clock edge, the following take effect and all in-flight work is discarded:
  - state=IDLE, counter=0, last_grant=IF.
  - if_rdata=dm_rdata=0.
  - All strobes, done, err and busy = 0; mem_addr=mem_wdata=0.
  - No done pulse is ever issued for an aborted transaction.
  - Memory data returning after reset is ignored.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE, grant decision:
  - Only dm_req high: grant DM.
  - Only if_req high: grant IF.
  - Both high: grant the port that is not last_grant. After reset the first tie goes to DM.
  - On grant: latch owner, address, wr (forced 0 for IF), wdata; update last_grant; go to ACCESS.
  - No request: stay in IDLE.
- ACCESS (1 cycle):
  - mem_en=1, mem_wr=latched wr, mem_addr/mem_wdata = latched values.
  - err=1 if latched addr[0]==1; the access proceeds unchanged.
  - Write: go to DONE.
  - Read: load counter=MEM_LAT-1, go to WAIT.
- WAIT:
  - counter!=0: decrement and stay.
  - counter==0 (the cycle mem_rdata is valid): capture mem_rdata into the owner's rdata register, go to DONE.
- DONE (1 cycle):
  - Owner's done=1.
  - The owner's rdata register is updated at this point and holds until that port's next read completes. The other port's rdata is untouched.
  - Writes leave dm_rdata unchanged.
  - Next state is always IDLE. A requester drops or renews req in the cycle after done; DONE never re-arbitrates.
- Latency from the request-sampled IDLE cycle to the done cycle:
  - Read: MEM_LAT+2 cycles.
  - Write: 2 cycles.
- Throughput: back-to-back reads from the same port take one transaction per MEM_LAT+3 cycles.
- Outputs: mem_en, mem_wr, err and done are registered state decodes. Stall outputs are combinational.
- Requests arriving in ACCESS, WAIT or DONE are not seen until the next IDLE. Inputs are sampled only in IDLE; changes during a transaction are ignored.
- Fairness: under continuous requests from both ports, grants alternate strictly DM, IF, DM, IF...

Test Plan:
- Reset, then if_req=1, if_addr=0x0010, memory returns 0xABCD, MEM_LAT=4 -> mem_en one cycle after request with mem_addr=0x0010, mem_wr=0; if_done exactly 6 cycles after request; if_rdata=0xABCD; if_stall high every cycle before done.
- dm_req=1, dm_wr=1, dm_addr=0x0200, dm_wdata=0x1234 -> mem_en=mem_wr=1 with those values; dm_done 2 cycles after request; dm_rdata unchanged.
- if_req and dm_req raised in the same cycle, both held and renewed for 4 transactions -> grant order DM, IF, DM, IF; the idle port's stall stays high.
- dm_addr=0x0201 read -> err pulses in the mem_en cycle only; the read completes normally with dm_done.
- rst driven low during WAIT of an IF read -> next cycle IDLE, busy=0, if_rdata=0, no if_done; late memory data ignored; a fresh request after reset completes normally.
- MEM_LAT=1 read -> done 3 cycles after request, data captured from the cycle after mem_en.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one single-port, fixed-latency memory between the fetch (read-only) and data requesters.
// Read done MEM_LAT+2 cycles after grant, write done after 2; a waiting port sees stall until its done.
module mem_arbiter #(
    parameter int MEM_LAT = 4,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    output logic          if_stall,
    input  logic          dm_req,
    input  logic          dm_wr,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_done,
    output logic          dm_stall,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          owner_dm;
    logic          last_dm;
    logic          lat_wr;
    logic          grant_dm;
    logic [AW-1:0] grant_addr;

    // A tie goes to whichever port did not win the previous grant
    assign grant_dm   = dm_req & (~if_req | ~last_dm);
    assign grant_addr = grant_dm ? dm_addr : if_addr;

    assign if_stall = if_req & ~if_done;
    assign dm_stall = dm_req & ~dm_done;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            owner_dm  <= 1'b0;
            last_dm   <= 1'b0;
            lat_wr    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
        end else begin
            mem_en  <= 1'b0;
            mem_wr  <= 1'b0;
            err     <= 1'b0;
            if_done <= 1'b0;
            dm_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        owner_dm  <= grant_dm;
                        last_dm   <= grant_dm;
                        lat_wr    <= grant_dm & dm_wr;
                        mem_addr  <= grant_addr;
                        mem_wdata <= dm_wdata;
                        mem_en    <= 1'b1;
                        mem_wr    <= grant_dm & dm_wr;
                        err       <= grant_addr[0];
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (lat_wr) begin
                        dm_done <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt   <= 4'(MEM_LAT - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Data is valid exactly this cycle; capture it so it is visible with done
                        if (owner_dm) begin
                            dm_rdata <= mem_rdata;
                            dm_done  <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_done  <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT 4 and 1) against a delayed-return memory responder.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req[2];
    logic [15:0] if_addr[2];
    logic [15:0] if_rdata[2];
    logic        if_done[2];
    logic        if_stall[2];
    logic        dm_req[2];
    logic        dm_wr[2];
    logic [15:0] dm_addr[2];
    logic [15:0] dm_wdata[2];
    logic [15:0] dm_rdata[2];
    logic        dm_done[2];
    logic        dm_stall[2];
    logic        mem_en[2];
    logic        mem_wr[2];
    logic [15:0] mem_addr[2];
    logic [15:0] mem_wdata[2];
    logic [15:0] mem_rdata[2];
    logic        busy[2];
    logic        err[2];

    int total = 0;
    int bad   = 0;

    // Responder storage (written only by the responder) and the bench's own reference memory
    logic [15:0] wmem[256];
    bit          wset[256];
    logic [15:0] pend_data[2];
    int          pend_cnt[2];
    logic [15:0] ref_mem[256];
    bit          ref_set[256];
    bit          last_dm[2];
    logic [15:0] exp_ifd[2];
    logic [15:0] exp_dmd[2];

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(4), .AW(16), .DW(16)) u0 (
        .clk(clk), .rst(rst),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]),
        .if_done(if_done[0]), .if_stall(if_stall[0]),
        .dm_req(dm_req[0]), .dm_wr(dm_wr[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
        .dm_rdata(dm_rdata[0]), .dm_done(dm_done[0]), .dm_stall(dm_stall[0]),
        .mem_en(mem_en[0]), .mem_wr(mem_wr[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0]), .err(err[0])
    );

    mem_arbiter #(.MEM_LAT(1), .AW(16), .DW(16)) u1 (
        .clk(clk), .rst(rst),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]),
        .if_done(if_done[1]), .if_stall(if_stall[1]),
        .dm_req(dm_req[1]), .dm_wr(dm_wr[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
        .dm_rdata(dm_rdata[1]), .dm_done(dm_done[1]), .dm_stall(dm_stall[1]),
        .mem_en(mem_en[1]), .mem_wr(mem_wr[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1]), .err(err[1])
    );

    function automatic logic [15:0] init_word(input logic [7:0] idx);
        return (idx == 8'h10) ? 16'hABCD : ({8'h00, idx} ^ 16'h5A5A) + 16'h0101;
    endfunction

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        return ref_set[a[7:0]] ? ref_mem[a[7:0]] : init_word(a[7:0]);
    endfunction

    // Memory: read data is presented only in the cycle exactly LAT cycles after mem_en, garbage otherwise
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_en[i] && mem_wr[i]) begin
                wmem[mem_addr[i][7:0]] <= mem_wdata[i];
                wset[mem_addr[i][7:0]] <= 1'b1;
            end
            if (mem_en[i] && !mem_wr[i]) begin
                pend_data[i] <= wset[mem_addr[i][7:0]] ? wmem[mem_addr[i][7:0]]
                                                       : init_word(mem_addr[i][7:0]);
                pend_cnt[i]  <= (i == 0) ? 4 : 1;
            end else if (pend_cnt[i] != 0) begin
                pend_cnt[i] <= pend_cnt[i] - 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++)
            mem_rdata[i] = (pend_cnt[i] == 1) ? pend_data[i] : 16'hDEAD;
    end

    // Drives one transaction and records what was observed; n counts cycles from the request-sampled cycle
    task automatic run_txn(input int i, input bit dm, input bit wr, input logic [15:0] addr,
                           input logic [15:0] wdata, output int done_at, output int en_cnt,
                           output int en_at, output logic [15:0] en_addr, output bit en_wr,
                           output logic [15:0] en_wdata, output int err_cnt, output int err_bad,
                           output int stall_bad);
        done_at = -1; en_cnt = 0; en_at = -1; en_addr = '0; en_wr = 1'b0; en_wdata = '0;
        err_cnt = 0; err_bad = 0; stall_bad = 0;
        @(negedge clk);
        if (dm) begin
            dm_req[i] = 1'b1; dm_wr[i] = wr; dm_addr[i] = addr; dm_wdata[i] = wdata;
        end else begin
            if_req[i] = 1'b1; if_addr[i] = addr;
        end
        for (int n = 0; n < 40; n++) begin
            #1;
            if (mem_en[i]) begin
                if (en_cnt == 0) begin
                    en_at = n; en_addr = mem_addr[i]; en_wr = mem_wr[i]; en_wdata = mem_wdata[i];
                end
                en_cnt++;
            end
            if (err[i]) begin
                err_cnt++;
                if (!mem_en[i]) err_bad++;
            end
            if (dm ? dm_done[i] : if_done[i]) begin
                done_at = n;
                if ((dm ? dm_stall[i] : if_stall[i]) !== 1'b0) stall_bad++;
                break;
            end
            if ((dm ? dm_stall[i] : if_stall[i]) !== 1'b1) stall_bad++;
            @(negedge clk);
        end
        if (dm) dm_req[i] = 1'b0; else if_req[i] = 1'b0;
        last_dm[i] = dm;
        if (dm && wr) begin
            ref_mem[addr[7:0]] = wdata; ref_set[addr[7:0]] = 1'b1;
        end else if (dm) exp_dmd[i] = ref_read(addr);
        else exp_ifd[i] = ref_read(addr);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({busy[i], mem_en[i], mem_wr[i], if_done[i], dm_done[i], err[i]} !== 6'b0) begin
                bad++;
                $display("FAIL reset_flags inst=%0d got=%b want=000000", i,
                         {busy[i], mem_en[i], mem_wr[i], if_done[i], dm_done[i], err[i]});
            end
            total++;
            if ({if_rdata[i], dm_rdata[i], mem_addr[i], mem_wdata[i]} !== 64'h0) begin
                bad++;
                $display("FAIL reset_regs inst=%0d got=%h want=0", i,
                         {if_rdata[i], dm_rdata[i], mem_addr[i], mem_wdata[i]});
            end
            exp_ifd[i] = '0; exp_dmd[i] = '0; last_dm[i] = 1'b0;
        end
        rst = 1'b1;
    endtask

    task automatic test_if_read();
        int d, ec, ea, rc, rb, sb; logic [15:0] a, w; bit ew;
        run_txn(0, 1'b0, 1'b0, 16'h0010, 16'h0, d, ec, ea, a, ew, w, rc, rb, sb);
        total++; if (ea !== 1 || ec !== 1) begin bad++; $display("FAIL if_read_en at=%0d cnt=%0d want at=1 cnt=1", ea, ec); end
        total++; if (a !== 16'h0010 || ew !== 1'b0) begin bad++; $display("FAIL if_read_addr got=%h wr=%0d want=0010 wr=0", a, ew); end
        total++; if (d !== 6) begin bad++; $display("FAIL if_read_latency got=%0d want=6", d); end
        total++; if (if_rdata[0] !== 16'hABCD) begin bad++; $display("FAIL if_read_data got=%h want=abcd", if_rdata[0]); end
        total++; if (sb !== 0) begin bad++; $display("FAIL if_read_stall bad_cycles=%0d want=0", sb); end
    endtask

    task automatic test_dm_write();
        int d, ec, ea, rc, rb, sb; logic [15:0] a, w; bit ew;
        run_txn(0, 1'b1, 1'b1, 16'h0200, 16'h1234, d, ec, ea, a, ew, w, rc, rb, sb);
        total++; if (a !== 16'h0200 || ew !== 1'b1 || w !== 16'h1234 || ec !== 1) begin
            bad++; $display("FAIL dm_write_bus addr=%h wr=%0d wdata=%h en=%0d want 0200/1/1234/1", a, ew, w, ec);
        end
        total++; if (d !== 2) begin bad++; $display("FAIL dm_write_latency got=%0d want=2", d); end
        total++; if (dm_rdata[0] !== exp_dmd[0]) begin bad++; $display("FAIL dm_write_rdata got=%h want=%h", dm_rdata[0], exp_dmd[0]); end
    endtask

    task automatic test_misaligned();
        int d, ec, ea, rc, rb, sb; logic [15:0] a, w; bit ew;
        run_txn(0, 1'b1, 1'b0, 16'h0201, 16'h0, d, ec, ea, a, ew, w, rc, rb, sb);
        total++; if (rc !== 1 || rb !== 0) begin bad++; $display("FAIL misaligned_err pulses=%0d outside_en=%0d want 1/0", rc, rb); end
        total++; if (d !== 6) begin bad++; $display("FAIL misaligned_latency got=%0d want=6", d); end
        total++; if (dm_rdata[0] !== exp_dmd[0]) begin bad++; $display("FAIL misaligned_data got=%h want=%h", dm_rdata[0], exp_dmd[0]); end
    endtask

    task automatic test_back_to_back();
        int t[$];
        @(negedge clk);
        if_req[0] = 1'b1; if_addr[0] = 16'h0010;
        for (int n = 0; n < 60 && t.size() < 2; n++) begin
            #1;
            if (if_done[0]) begin
                t.push_back(n);
                if (t.size() == 2) if_req[0] = 1'b0;
            end
            @(negedge clk);
        end
        if_req[0] = 1'b0;
        last_dm[0] = 1'b0; exp_ifd[0] = ref_read(16'h0010);
        total++;
        if (t.size() != 2) begin bad++; $display("FAIL back_to_back_timeout dones=%0d want=2", t.size()); end
        else if (t[1] - t[0] != 7) begin bad++; $display("FAIL back_to_back_period got=%0d want=7", t[1] - t[0]); end
    endtask

    task automatic test_reset_abort();
        int seen;
        @(negedge clk);
        if_req[0] = 1'b1; if_addr[0] = 16'h0020;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        total++; if (busy[0] !== 1'b0 || if_rdata[0] !== 16'h0 || if_done[0] !== 1'b0) begin
            bad++; $display("FAIL abort_state busy=%0d if_rdata=%h if_done=%0d want 0/0000/0", busy[0], if_rdata[0], if_done[0]);
        end
        if_req[0] = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin exp_ifd[i] = '0; exp_dmd[i] = '0; last_dm[i] = 1'b0; end
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk); #1;
            if (if_done[0] || dm_done[0] || busy[0] || mem_en[0] || if_rdata[0] !== 16'h0) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_quiet active_cycles=%0d want=0", seen); end
        begin
            int d, ec, ea, rc, rb, sb; logic [15:0] a, w; bit ew;
            run_txn(0, 1'b0, 1'b0, 16'h0020, 16'h0, d, ec, ea, a, ew, w, rc, rb, sb);
            total++; if (d !== 6 || if_rdata[0] !== exp_ifd[0]) begin
                bad++; $display("FAIL abort_fresh latency=%0d data=%h want 6/%h", d, if_rdata[0], exp_ifd[0]);
            end
        end
    endtask

    task automatic test_fairness();
        bit got[$];
        bit nxt;
        int stall_bad = 0;
        nxt = !last_dm[0];
        @(negedge clk);
        if_req[0] = 1'b1; if_addr[0] = 16'h0050;
        dm_req[0] = 1'b1; dm_wr[0] = 1'b0; dm_addr[0] = 16'h0040;
        for (int n = 0; n < 200 && got.size() < 4; n++) begin
            #1;
            if (dm_done[0]) begin got.push_back(1'b1); if (if_stall[0] !== 1'b1) stall_bad++; end
            if (if_done[0]) begin got.push_back(1'b0); if (dm_stall[0] !== 1'b1) stall_bad++; end
            if (got.size() >= 4) break;
            @(negedge clk);
        end
        if_req[0] = 1'b0; dm_req[0] = 1'b0;
        exp_ifd[0] = ref_read(16'h0050); exp_dmd[0] = ref_read(16'h0040);
        total++; if (got.size() != 4) begin bad++; $display("FAIL fairness_timeout grants=%0d want=4", got.size()); end
        for (int k = 0; k < got.size(); k++) begin
            total++;
            if (got[k] !== nxt) begin bad++; $display("FAIL fairness_order idx=%0d got_dm=%0d want_dm=%0d", k, got[k], nxt); end
            nxt = !nxt;
        end
        if (got.size() > 0) last_dm[0] = got[got.size()-1];
        total++; if (stall_bad !== 0) begin bad++; $display("FAIL fairness_idle_stall bad=%0d want=0", stall_bad); end
        repeat (2) @(negedge clk);
        #1;
        total++; if (busy[0] !== 1'b0 || if_rdata[0] !== exp_ifd[0] || dm_rdata[0] !== exp_dmd[0]) begin
            bad++; $display("FAIL fairness_end busy=%0d if=%h dm=%h want 0/%h/%h", busy[0], if_rdata[0], dm_rdata[0], exp_ifd[0], exp_dmd[0]);
        end
    endtask

    task automatic test_random();
        int d, ec, ea, rc, rb, sb; logic [15:0] a, w; bit ew;
        bit dm, wr; logic [15:0] addr, wdata;
        for (int k = 0; k < 24; k++) begin
            dm    = 1'($urandom_range(0, 1));
            wr    = dm & 1'($urandom_range(0, 1));
            addr  = 16'($urandom_range(0, 31) * 2);
            wdata = 16'($urandom);
            run_txn(0, dm, wr, addr, wdata, d, ec, ea, a, ew, w, rc, rb, sb);
            total++; if (d !== (wr ? 2 : 6) || a !== addr || ew !== wr || rc !== 0) begin
                bad++; $display("FAIL random_txn k=%0d lat=%0d addr=%h wr=%0d err=%0d want %0d/%h/%0d/0", k, d, a, ew, rc, wr ? 2 : 6, addr, wr);
            end
            total++; if (if_rdata[0] !== exp_ifd[0] || dm_rdata[0] !== exp_dmd[0]) begin
                bad++; $display("FAIL random_rdata k=%0d if=%h dm=%h want %h/%h", k, if_rdata[0], dm_rdata[0], exp_ifd[0], exp_dmd[0]);
            end
        end
    endtask

    task automatic test_lat1();
        int d, ec, ea, rc, rb, sb; logic [15:0] a, w; bit ew;
        run_txn(1, 1'b1, 1'b0, 16'h0030, 16'h0, d, ec, ea, a, ew, w, rc, rb, sb);
        total++; if (d !== 3 || ea !== 1) begin bad++; $display("FAIL lat1_dm_timing done=%0d en=%0d want 3/1", d, ea); end
        total++; if (dm_rdata[1] !== exp_dmd[1]) begin bad++; $display("FAIL lat1_dm_data got=%h want=%h", dm_rdata[1], exp_dmd[1]); end
        run_txn(1, 1'b0, 1'b0, 16'h0010, 16'h0, d, ec, ea, a, ew, w, rc, rb, sb);
        total++; if (d !== 3 || if_rdata[1] !== exp_ifd[1]) begin
            bad++; $display("FAIL lat1_if done=%0d data=%h want 3/%h", d, if_rdata[1], exp_ifd[1]);
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if_req[i] = 1'b0; if_addr[i] = '0;
            dm_req[i] = 1'b0; dm_wr[i] = 1'b0; dm_addr[i] = '0; dm_wdata[i] = '0;
        end
        test_reset();
        test_if_read();
        test_dm_write();
        test_misaligned();
        test_back_to_back();
        test_reset_abort();
        test_fairness();
        test_random();
        test_lat1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
